// File: rtl/girlanda_sequencer.sv
// -----------------------------------------------------------------------------
// girlanda_sequencer
//   Sequencer for the 5-LED red/green garland. The active-low front-panel
//   button is synchronised and debounced. Each accepted press advances a
//   4-entry pattern mode. Registered red/green LED vectors are animated by a
//   programmable step prescaler.
//
// Ports
//   clk           in   1  system clock, all state on rising edge
//   reset         in   1  asynchronous, active-low reset
//   button        in   1  raw push button, active-low, asynchronous to clk
//   run           in   1  1 = animation advances, 0 = position/prescaler hold
//   red           out  5  red LED vector (registered), bit i = LED i
//   green         out  5  green LED vector (registered)
//   mode          out  2  current pattern mode
//   mode_changed  out  1  one-cycle pulse when mode advances
//   step_tick     out  1  one-cycle pulse on each animation step
// -----------------------------------------------------------------------------
module girlanda_sequencer #(
  parameter int DEBOUNCE = 25,
  parameter int STEP_DIV = 50,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  input  logic       run,
  output logic [4:0] red,
  output logic [4:0] green,
  output logic [1:0] mode,
  output logic       mode_changed,
  output logic       step_tick
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HELD  = 2'd2
  } db_state_t;

  localparam logic [CNT_W-1:0] L_DB_LAST   = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] L_STEP_LAST = CNT_W'(STEP_DIV - 1);

  logic             r_sync1;
  logic             r_sync2;
  db_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic             r_mode_changed;
  logic [CNT_W-1:0] r_presc;
  logic [2:0]       r_pos;
  logic             r_step_tick;
  logic [4:0]       r_red;
  logic [4:0]       r_green;

  logic             w_btn_s;
  logic             w_accept;
  logic [4:0]       w_red;
  logic [4:0]       w_green;
  logic [5:0]       w_fill;

  assign w_btn_s = r_sync2;

  // Accept is decoded from the current COUNT state so that the mode register
  // and the mode_changed pulse update on the very edge the last low sample
  // is counted.
  assign w_accept = (r_state == ST_COUNT) && !w_btn_s && (r_cnt == L_DB_LAST);

  // Two-flop synchroniser for the asynchronous button; idles high (released).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= button;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM plus the mode register it advances.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_mode         <= 2'd0;
      r_mode_changed <= 1'b0;
    end else begin
      r_mode_changed <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_btn_s) begin
            // The first low sample already counts as one.
            r_state <= ST_COUNT;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        end
        ST_COUNT: begin
          if (w_btn_s) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == L_DB_LAST) begin
            r_state <= ST_HELD;
            r_cnt   <= '0;
          end else begin
            r_state <= ST_COUNT;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        ST_HELD: begin
          // Holding never re-fires; only a release re-arms the detector.
          if (w_btn_s) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_HELD;
          end
          r_cnt <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
      if (w_accept) begin
        r_mode         <= r_mode + 2'd1;
        r_mode_changed <= 1'b1;
      end else begin
        r_mode         <= r_mode;
      end
    end
  end

  // Step prescaler and animation position; a mode change restarts both and
  // swallows any step that would coincide with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc     <= '0;
      r_pos       <= 3'd0;
      r_step_tick <= 1'b0;
    end else if (w_accept) begin
      r_presc     <= '0;
      r_pos       <= 3'd0;
      r_step_tick <= 1'b0;
    end else if (run) begin
      if (r_presc == L_STEP_LAST) begin
        r_presc     <= '0;
        r_step_tick <= 1'b1;
        r_pos       <= (r_pos == 3'd4) ? 3'd0 : (r_pos + 3'd1);
      end else begin
        r_presc     <= r_presc + CNT_W'(1);
        r_step_tick <= 1'b0;
      end
    end else begin
      r_step_tick <= 1'b0;
    end
  end

  assign w_fill = (6'd2 << r_pos) - 6'd1;

  // Pattern decode from the current mode and position.
  always_comb begin
    w_red   = 5'b11111;
    w_green = 5'b00000;
    case (r_mode)
      2'd0: begin
        w_red   = 5'b11111;
        w_green = 5'b00000;
      end
      2'd1: begin
        if (r_pos[0] == 1'b0) begin
          w_red   = 5'b10101;
          w_green = 5'b01010;
        end else begin
          w_red   = 5'b01010;
          w_green = 5'b10101;
        end
      end
      2'd2: begin
        w_red   = 5'b00001 << r_pos;
        w_green = ~(5'b00001 << r_pos) & 5'b11111;
      end
      2'd3: begin
        w_red   = w_fill[4:0];
        w_green = 5'b00000;
      end
      default: begin
        w_red   = 5'b11111;
        w_green = 5'b00000;
      end
    endcase
  end

  // LED output registers; they lag mode/pos by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_red   <= 5'b11111;
      r_green <= 5'b00000;
    end else begin
      r_red   <= w_red;
      r_green <= w_green;
    end
  end

  assign red          = r_red;
  assign green        = r_green;
  assign mode         = r_mode;
  assign mode_changed = r_mode_changed;
  assign step_tick    = r_step_tick;

endmodule

// File: tb/tb_girlanda_sequencer.sv
module tb_girlanda_sequencer;

  logic       clk;
  logic       reset;
  logic       button;
  logic       run;
  logic [4:0] red;
  logic [4:0] green;
  logic [1:0] mode;
  logic       mode_changed;
  logic       step_tick;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0] mode;
    logic [2:0] pos;
    logic [4:0] red;
    logic [4:0] green;
  } vec_t;

  vec_t       tbl[20];
  vec_t       led_q[$];
  logic [1:0] mode_q[$];

  girlanda_sequencer #(
    .DEBOUNCE(4),
    .STEP_DIV(3),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button(button),
    .run(run),
    .red(red),
    .green(green),
    .mode(mode),
    .mode_changed(mode_changed),
    .step_tick(step_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void set_vec(input int i, input logic [1:0] m, input logic [2:0] p,
                                  input logic [4:0] r, input logic [4:0] g);
    tbl[i].mode  = m;
    tbl[i].pos   = p;
    tbl[i].red   = r;
    tbl[i].green = g;
  endfunction

  function automatic int find_vec(input logic [1:0] m, input logic [2:0] p);
    for (int i = 0; i < 20; i++) begin
      if (tbl[i].mode == m && tbl[i].pos == p) return i;
    end
    return 0;
  endfunction

  // Hold the button until one accept is seen; check latency, mode and LEDs.
  task automatic press(input logic [1:0] exp_m);
    int   got;
    int   hit;
    vec_t e;
    logic [1:0] m;
    got = 0;
    hit = 0;
    e = tbl[find_vec(exp_m, 3'd0)];
    mode_q.push_back(exp_m);
    button = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (mode_changed) begin
        got++;
        if (got == 1) begin
          hit = c;
          check("accept_latency", c, 32'd6);
          if (mode_q.size() > 0) begin
            m = mode_q.pop_front();
            check("mode_after_accept", mode, m);
          end
        end
      end
      if (hit != 0 && c == hit + 1) begin
        check("pulse_width", mode_changed, 32'd0);
        check("red_new_mode", red, e.red);
        check("green_new_mode", green, e.green);
      end
    end
    check("accept_count", got, 32'd1);
    mode_q.delete();
    button = 1'b1;
    repeat (5) tick();
  endtask

  // Run the animation for nsteps steps, comparing each step's LEDs, then freeze.
  task automatic animate(input logic [1:0] m, input int nsteps);
    int   gap;
    int   budget;
    vec_t e;
    for (int i = 1; i <= nsteps; i++) led_q.push_back(tbl[find_vec(m, 3'(i % 5))]);
    run = 1'b1;
    gap = 0;
    budget = 0;
    while (led_q.size() > 0 && budget < 100) begin
      tick();
      gap++;
      budget++;
      if (step_tick) begin
        check("step_period", gap, 32'd3);
        tick();
        gap = 1;
        budget++;
        e = led_q.pop_front();
        check("red_step", red, e.red);
        check("green_step", green, e.green);
        check("tick_width", step_tick, 32'd0);
      end
    end
    if (led_q.size() > 0) begin
      check("step_timeout", led_q.size(), 32'd0);
      led_q.delete();
    end
    run = 1'b0;
    e = tbl[find_vec(m, 3'(nsteps % 5))];
    for (int c = 0; c < 8; c++) begin
      tick();
      check("frozen_tick", step_tick, 32'd0);
      check("frozen_red", red, e.red);
    end
  endtask

  initial begin
    int got;
    int hit;

    // Expected decode, mode x pos.
    for (int p = 0; p < 5; p++) set_vec(p, 2'd0, 3'(p), 5'b11111, 5'b00000);
    set_vec(5,  2'd1, 3'd0, 5'b10101, 5'b01010);
    set_vec(6,  2'd1, 3'd1, 5'b01010, 5'b10101);
    set_vec(7,  2'd1, 3'd2, 5'b10101, 5'b01010);
    set_vec(8,  2'd1, 3'd3, 5'b01010, 5'b10101);
    set_vec(9,  2'd1, 3'd4, 5'b10101, 5'b01010);
    set_vec(10, 2'd2, 3'd0, 5'b00001, 5'b11110);
    set_vec(11, 2'd2, 3'd1, 5'b00010, 5'b11101);
    set_vec(12, 2'd2, 3'd2, 5'b00100, 5'b11011);
    set_vec(13, 2'd2, 3'd3, 5'b01000, 5'b10111);
    set_vec(14, 2'd2, 3'd4, 5'b10000, 5'b01111);
    set_vec(15, 2'd3, 3'd0, 5'b00001, 5'b00000);
    set_vec(16, 2'd3, 3'd1, 5'b00011, 5'b00000);
    set_vec(17, 2'd3, 3'd2, 5'b00111, 5'b00000);
    set_vec(18, 2'd3, 3'd3, 5'b01111, 5'b00000);
    set_vec(19, 2'd3, 3'd4, 5'b11111, 5'b00000);

    reset  = 1'b0;
    button = 1'b1;
    run    = 1'b0;
    repeat (3) tick();
    check("rst_red", red, 32'h1f);
    check("rst_green", green, 32'h0);
    check("rst_mode", mode, 32'd0);
    check("rst_mc", mode_changed, 32'd0);
    check("rst_tick", step_tick, 32'd0);
    reset = 1'b1;

    // Idle after reset: steady pattern, no pulses.
    for (int c = 0; c < 20; c++) begin
      tick();
      check("idle_mc", mode_changed, 32'd0);
      check("idle_tick", step_tick, 32'd0);
      check("idle_red", red, 32'h1f);
      check("idle_green", green, 32'h0);
    end

    // Three-cycle glitch is rejected.
    button = 1'b0;
    repeat (3) tick();
    button = 1'b1;
    got = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (mode_changed) got++;
    end
    check("glitch_pulses", got, 32'd0);
    check("glitch_mode", mode, 32'd0);

    // Presses cycle the modes 1,2,3,0 with animation in each.
    press(2'd1);
    animate(2'd1, 6);
    press(2'd2);
    animate(2'd2, 6);
    press(2'd3);
    animate(2'd3, 6);
    press(2'd0);
    animate(2'd0, 3);
    press(2'd1);

    // Reset while counting a held press; the press must debounce again.
    button = 1'b0;
    repeat (4) tick();
    #2;
    reset = 1'b0;
    #1;
    check("midrst_mode", mode, 32'd0);
    check("midrst_red", red, 32'h1f);
    check("midrst_green", green, 32'h0);
    check("midrst_mc", mode_changed, 32'd0);
    check("midrst_tick", step_tick, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    got = 0;
    hit = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (mode_changed) begin
        got++;
        if (got == 1) begin
          hit = c;
          check("midrst_latency", c, 32'd6);
        end
      end
    end
    check("midrst_count", got, 32'd1);
    check("midrst_newmode", mode, 32'd1);
    button = 1'b1;
    repeat (5) tick();
    animate(2'd1, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
